// File: rtl/axil_reg_bank.sv
// AXI-Lite register bank: magic/ID word, write-1-to-pulse register, RW control
// registers driven to the role and RO status words sampled from the role.
module axil_reg_bank #(
    parameter int                      DATA_WIDTH = 32,
    parameter int                      ADDR_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0]   MAGIC_NUM  = 'h0011_4514,
    parameter int                      CTRL_NUM   = 4,
    parameter int                      STAT_NUM   = 4,
    parameter logic [DATA_WIDTH-1:0]   CTRL_RST   = '0
) (
    input  logic                                              sys_clk,
    input  logic                                              perif_rst_n,
    input  logic [ADDR_WIDTH-1:0]                             s_axil_awaddr,
    input  logic                                              s_axil_awvalid,
    output logic                                              s_axil_awready,
    input  logic [DATA_WIDTH-1:0]                             s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]                           s_axil_wstrb,
    input  logic                                              s_axil_wvalid,
    output logic                                              s_axil_wready,
    output logic [1:0]                                        s_axil_bresp,
    output logic                                              s_axil_bvalid,
    input  logic                                              s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]                             s_axil_araddr,
    input  logic                                              s_axil_arvalid,
    output logic                                              s_axil_arready,
    output logic [DATA_WIDTH-1:0]                             s_axil_rdata,
    output logic [1:0]                                        s_axil_rresp,
    output logic                                              s_axil_rvalid,
    input  logic                                              s_axil_rready,
    output logic [CTRL_NUM*DATA_WIDTH-1:0]                    ctrl_o,
    output logic [DATA_WIDTH-1:0]                             pulse_o,
    input  logic [((STAT_NUM > 0) ? STAT_NUM : 1)*DATA_WIDTH-1:0] stat_i
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [IW-1:0] IDX_PULSE = IW'(1);
    localparam logic [IW-1:0] CTRL_LO   = IW'(2);
    localparam logic [IW-1:0] CTRL_HI   = IW'(2 + CTRL_NUM);
    localparam logic [IW-1:0] STAT_HI   = IW'(2 + CTRL_NUM + STAT_NUM);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("axil_reg_bank: only DATA_WIDTH=32 is supported");
        end
        if (CTRL_NUM < 1 || CTRL_NUM > 64 || STAT_NUM < 0 || STAT_NUM > 64) begin : g_bad_count
            $error("axil_reg_bank: CTRL_NUM must be 1..64 and STAT_NUM 0..64");
        end
    endgenerate

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t               w_state_reg, w_state_next;
    r_state_t               r_state_reg, r_state_next;
    logic                   active_reg;
    logic                   aw_held_reg, w_held_reg;
    logic [IW-1:0]          aw_idx_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;
    logic [NB-1:0]          wstrb_reg;
    logic [1:0]             bresp_reg, rresp_reg;
    logic [DATA_WIDTH-1:0]  pulse_reg, rdata_reg;
    logic [DATA_WIDTH-1:0]  ctrl_reg [CTRL_NUM];

    logic                   aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0]          wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]  wr_data, wr_mask, rd_data;
    logic [NB-1:0]          wr_strb;
    logic                   unused_addr_lsbs;

    // Maps a word index to its response code; writes to RO words are SLVERR.
    function automatic logic [1:0] decode_resp(input logic [IW-1:0] idx, input logic is_write);
        logic [1:0] resp;
        resp = RESP_DECERR;
        if (idx == '0)
            resp = is_write ? RESP_SLVERR : RESP_OKAY;
        else if (idx == IDX_PULSE || (idx >= CTRL_LO && idx < CTRL_HI))
            resp = RESP_OKAY;
        else if (idx >= CTRL_HI && idx < STAT_HI)
            resp = is_write ? RESP_SLVERR : RESP_OKAY;
        return resp;
    endfunction

    assign s_axil_awready = active_reg && (w_state_reg == W_IDLE) && !aw_held_reg;
    assign s_axil_wready  = active_reg && (w_state_reg == W_IDLE) && !w_held_reg;
    assign s_axil_bvalid  = (w_state_reg == W_RESP);
    assign s_axil_bresp   = bresp_reg;
    assign s_axil_arready = active_reg && (r_state_reg == R_IDLE);
    assign s_axil_rvalid  = (r_state_reg == R_DATA);
    assign s_axil_rdata   = rdata_reg;
    assign s_axil_rresp   = rresp_reg;
    assign pulse_o        = pulse_reg;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    // The commit uses whichever half arrives this cycle straight off the bus.
    assign wr_idx  = aw_held_reg ? aw_idx_reg : s_axil_awaddr[ADDR_WIDTH-1:2];
    assign wr_data = w_held_reg ? wdata_reg : s_axil_wdata;
    assign wr_strb = w_held_reg ? wstrb_reg : s_axil_wstrb;
    assign rd_idx  = s_axil_araddr[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = &{1'b0, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
        end
        for (gi = 0; gi < CTRL_NUM; gi++) begin : g_ctrl_out
            assign ctrl_o[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_reg[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = w_state_reg;
        commit       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs)) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil_bready)
                    w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            active_reg  <= 1'b0;
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
            pulse_reg   <= '0;
        end else begin
            active_reg  <= 1'b1;
            w_state_reg <= w_state_next;
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bresp_reg   <= decode_resp(wr_idx, 1'b1);
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    aw_idx_reg  <= s_axil_awaddr[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    wdata_reg  <= s_axil_wdata;
                    wstrb_reg  <= s_axil_wstrb;
                end
            end
            pulse_reg <= (commit && wr_idx == IDX_PULSE) ? (wr_data & wr_mask) : '0;
        end
    end

    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            for (int k = 0; k < CTRL_NUM; k++)
                ctrl_reg[k] <= CTRL_RST;
        end else if (commit) begin
            for (int k = 0; k < CTRL_NUM; k++)
                if (wr_idx == IW'(2 + k))
                    ctrl_reg[k] <= (ctrl_reg[k] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Reads see ctrl_reg before any same-edge commit, i.e. the pre-write value.
    always_comb begin
        rd_data = '0;
        if (rd_idx == '0)
            rd_data = MAGIC_NUM;
        for (int k = 0; k < CTRL_NUM; k++)
            if (rd_idx == IW'(2 + k))
                rd_data = ctrl_reg[k];
        for (int k = 0; k < STAT_NUM; k++)
            if (rd_idx == IW'(2 + CTRL_NUM + k))
                rd_data = stat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (s_axil_rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            r_state_reg <= R_IDLE;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            r_state_reg <= r_state_next;
            if (ar_hs) begin
                rdata_reg <= rd_data;
                rresp_reg <= decode_resp(rd_idx, 1'b0);
            end
        end
    end
endmodule
